// File: rtl/common_dffram_arb2_pkg.sv
// Shared types for the two-requester DFF RAM access controller.
package common_dffram_arb2_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned NUM_REQ = 2;

  // Round-robin pointer after a grant: favour the requester that did not win.
  function automatic logic rr_next(input logic [NUM_REQ-1:0] grant);
    return grant[0];
  endfunction

endpackage

// File: rtl/common_rrarb2.sv
// Two-way round-robin arbiter; the pointer advances only on an accepted grant.
module common_rrarb2
  import common_dffram_arb2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic rr_ptr_q;

  // A lone requester always wins; contention is settled by the pointer.
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else if (accept && (|grant)) begin
      rr_ptr_q <= rr_next(grant);
    end
  end

endmodule

// File: rtl/common_dffram_arb2.sv
// Single-port DFF RAM controller: walks the RAM to INIT_VALUE, then shares
// the port between two valid/ready requesters with round-robin arbitration.
module common_dffram_arb2
  import common_dffram_arb2_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           ADDR_WIDTH    = 4,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_dout,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  localparam state_e      RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    grant;
  logic                  run;
  logic                  cnt_last;
  logic                  rd0_hs, rd1_hs;

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);
  assign cnt_last  = (cnt_q == ADDR_WIDTH'(DEPTH - 1));

  common_rrarb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .accept (run),
    .grant  (grant)
  );

  assign req0_ready = run & grant[0];
  assign req1_ready = run & grant[1];
  assign rd0_hs     = req0_ready & ~req0_we;
  assign rd1_hs     = req1_ready & ~req1_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // init_req wins over the walk; a handshake in the same cycle is unaffected
  // because ready is decoded from the registered state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_last) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
    if (init_req) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  // RAM port mux: init walker, then the arbitration winner.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (init_busy) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cnt_q;
      ram_din  = INIT_VALUE;
    end else if (req1_ready) begin
      ram_en   = 1'b1;
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_din  = req1_din;
    end else if (req0_ready) begin
      ram_en   = 1'b1;
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_din  = req0_din;
    end
  end

  // Read data is captured at the handshake edge since the RAM reads asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_dout  <= '0;
      resp1_dout  <= '0;
    end else begin
      resp0_valid <= rd0_hs;
      resp1_valid <= rd1_hs;
      if (rd0_hs) begin
        resp0_dout <= ram_dout;
      end
      if (rd1_hs) begin
        resp1_dout <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_common_dffram_arb2.sv
// Table-driven bench for common_dffram_arb2 with a read-response scoreboard.
module tb_common_dffram_arb2;

  localparam logic [7:0] IV = 8'hA5;

  logic       clk, reset, init_req, init_busy;
  logic       req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [1:0] req0_addr, req1_addr, ram_addr;
  logic [7:0] req0_din, req1_din, resp0_dout, resp1_dout, ram_din, ram_dout;
  logic       resp0_valid, resp1_valid, ram_en, ram_we;

  common_dffram_arb2 #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_din(req0_din),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_din(req1_din),
    .resp0_valid(resp0_valid), .resp0_dout(resp0_dout),
    .resp1_valid(resp1_valid), .resp1_dout(resp1_dout),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM: synchronous write, asynchronous read.
  logic [7:0] mem [4];
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v0, we0;
    logic [1:0] a0;
    logic [7:0] d0;
    logic       v1, we1;
    logic [1:0] a1;
    logic [7:0] d1;
    logic       ir, r0, r1;
  } vec_t;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] shadow [4];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  vec_t       tbl [$];

  function automatic vec_t mk(input logic v0, input logic we0, input logic [1:0] a0,
                              input logic [7:0] d0, input logic v1, input logic we1,
                              input logic [1:0] a1, input logic [7:0] d1,
                              input logic ir, input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.ir = ir; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_din = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_din = v.d1;
    init_req   = v.ir;
  endtask

  // One RUN cycle: check readies mid-cycle, then the response after the edge.
  task automatic step(input vec_t v, input string tag);
    logic rd0, rd1;
    drive(v);
    @(negedge clk);
    chk({tag, " busy"},   32'(init_busy), 32'(0));
    chk({tag, " ready0"}, 32'(req0_ready), 32'(v.r0));
    chk({tag, " ready1"}, 32'(req1_ready), 32'(v.r1));
    chk({tag, " ram_en"}, 32'(ram_en), 32'(v.r0 | v.r1));
    rd0 = v.v0 & v.r0 & ~v.we0;
    rd1 = v.v1 & v.r1 & ~v.we1;
    if (rd0) q0.push_back(shadow[v.a0]);
    if (rd1) q1.push_back(shadow[v.a1]);
    if (v.v0 && v.r0 && v.we0) shadow[v.a0] = v.d0;
    if (v.v1 && v.r1 && v.we1) shadow[v.a1] = v.d1;
    @(posedge clk);
    #1;
    chk({tag, " resp0_valid"}, 32'(resp0_valid), 32'(rd0));
    chk({tag, " resp1_valid"}, 32'(resp1_valid), 32'(rd1));
    if (resp0_valid && q0.size() > 0) chk({tag, " resp0_dout"}, 32'(resp0_dout), 32'(q0.pop_front()));
    if (resp1_valid && q1.size() > 0) chk({tag, " resp1_dout"}, 32'(resp1_dout), 32'(q1.pop_front()));
  endtask

  // INIT walk of n cycles starting at counter value first; readies must stay low.
  task automatic init_walk(input int first, input int n, input string tag);
    init_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " busy"},     32'(init_busy), 32'(1));
      chk({tag, " ram_addr"}, 32'(ram_addr), 32'(first + i));
      chk({tag, " ram_we"},   32'(ram_en & ram_we), 32'(1));
      chk({tag, " ram_din"},  32'(ram_din), 32'(IV));
      chk({tag, " ready0"},   32'(req0_ready), 32'(0));
      chk({tag, " ready1"},   32'(req1_ready), 32'(0));
      shadow[2'(first + i)] = IV;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    reset = 1'b0;
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy",        32'(init_busy), 32'(1));
    chk("rst resp0_valid", 32'(resp0_valid), 32'(0));
    chk("rst resp1_valid", 32'(resp1_valid), 32'(0));
    chk("rst resp0_dout",  32'(resp0_dout), 32'(0));
    chk("rst resp1_dout",  32'(resp1_dout), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(mk(1,0,2,0, 0,0,0,0, 0,0,0));
    init_walk(0, 4, "init0");

    // Read-after-init, write/read, contention, lone requester, init_req with handshake.
    tbl.push_back(mk(1,0,2,8'h00, 0,0,0,8'h00, 0,1,0));
    tbl.push_back(mk(1,1,1,8'h3C, 0,0,0,8'h00, 0,1,0));
    tbl.push_back(mk(0,0,0,8'h00, 1,0,1,8'h00, 0,0,1));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1,0,1,8'h00, 1,0,3,8'h00, 0, 1'(i % 2 == 0), 1'(i % 2 == 1)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,8'h00, 1,0,2,8'h00, 0,0,1));
    tbl.push_back(mk(1,0,1,8'h00, 1,0,3,8'h00, 0,1,0));
    tbl.push_back(mk(1,0,3,8'h00, 0,0,0,8'h00, 1,1,0));
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    init_walk(0, 4, "init1");
    step(mk(0,0,0,8'h00, 1,0,1,8'h00, 0,0,1), "post_init_rd");
    chk("post_init value", 32'(shadow[1]), 32'(IV));

    // init_req during INIT restarts the walk.
    step(mk(0,0,0,8'h00, 0,0,0,8'h00, 1,0,0), "ireq_idle");
    init_walk(0, 2, "init2a");
    init_req = 1'b1;
    @(negedge clk);
    chk("restart addr", 32'(ram_addr), 32'(2));
    @(posedge clk);
    #1;
    init_walk(0, 4, "init2b");

    // Reset in the middle of INIT at cnt=2.
    step(mk(0,0,0,8'h00, 0,0,0,8'h00, 1,0,0), "ireq_idle2");
    init_walk(0, 2, "init3a");
    @(negedge clk);
    chk("pre_rst addr", 32'(ram_addr), 32'(2));
    reset = 1'b0;
    #1;
    chk("mid_rst busy", 32'(init_busy), 32'(1));
    chk("mid_rst addr", 32'(ram_addr), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    init_walk(0, 4, "init3b");

    // Reset right after a read handshake drops the response.
    drive(mk(1,0,0,8'h00, 0,0,0,8'h00, 0,0,0));
    @(negedge clk);
    chk("drop ready0", 32'(req0_ready), 32'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("drop resp0_valid", 32'(resp0_valid), 32'(0));
    chk("drop resp0_dout",  32'(resp0_dout), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0));
    init_walk(0, 4, "init4");
    step(mk(1,0,1,8'h00, 0,0,0,8'h00, 0,1,0), "final_rd");

    chk("q0 drained", 32'(q0.size()), 32'(0));
    chk("q1 drained", 32'(q1.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/common_dffram_arb2.md
# common_dffram_arb2

Two-requester access controller for a single-port DFF RAM (one address, one write, asynchronous read). It walks the RAM to a known value after reset or on request, then shares the single port between two independent valid/ready requesters with round-robin arbitration, returning read data one cycle after acceptance. It sits between small core-side tables, such as predictor or tag arrays, and the `common_dffram_1a1w1r` instance that holds them.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width; DEPTH = 2^ADDR_WIDTH.
- `INIT_ON_RESET`, 1: 1 = enter INIT after reset; 0 = enter RUN directly.
- `INIT_VALUE`, 0 (DATA_WIDTH bits): word written to every entry during INIT.

Ports (i = 0, 1). One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `init_req` in 1: pulse; restarts RAM initialisation.
- `init_busy` out 1: high while in INIT.
- `req{i}_valid` in 1: request present.
- `req{i}_ready` out 1: request accepted this cycle.
- `req{i}_we` in 1: 1 = write, 0 = read.
- `req{i}_addr` in ADDR_WIDTH: target entry.
- `req{i}_din` in DATA_WIDTH: write data.
- `resp{i}_valid` out 1: read data valid, one-cycle pulse.
- `resp{i}_dout` out DATA_WIDTH: read data.
- `ram_addr` out ADDR_WIDTH, `ram_en` out 1, `ram_we` out 1, `ram_din` out DATA_WIDTH: RAM port drive.
- `ram_dout` in DATA_WIDTH: RAM asynchronous read data.

## Operation
- States:
  - INIT: `init_busy`=1, both readies 0. Drives `ram_en`=`ram_we`=1, `ram_addr`=cnt, `ram_din`=INIT_VALUE; cnt increments each cycle. At cnt==DEPTH-1, the next state is RUN and cnt wraps to 0.
  - RUN: arbitrates requesters.
- Transitions:
  - `init_req` in RUN → INIT next cycle, cnt=0.
  - `init_req` in INIT → cnt restarts at 0.
  - A handshake in the same cycle as `init_req` still completes.
- Grant:
  - Only one valid → that requester.
  - Both valid → requester selected by `rr_ptr`.
  - `req{i}_ready` = RUN & grant_i. Ready depends combinationally on valid; requesters must not make valid depend on ready.
- Accepted request: `ram_en`=1, `ram_we`=`req_we`, `ram_addr`/`ram_din` from the winner. With no grant, `ram_en`=0 and `ram_we`=0.
- `rr_ptr`: on any accepted request, set to the other requester. Otherwise hold.
- Read response: `resp{i}_dout` <= `ram_dout` and `resp{i}_valid` <= 1 on the cycle after an accepted read. Writes produce no response. `resp_dout` holds its value until the next read response to that requester.
- Write then read of the same address on consecutive cycles returns the new data (RAM updates at the edge).

## Timing
- Reset values:
  - state = INIT if INIT_ON_RESET, else RUN.
  - cnt = 0, `rr_ptr` = 0.
  - `resp{i}_valid` = 0, `resp{i}_dout` = 0.
  - `init_busy` = INIT_ON_RESET.
- INIT lasts exactly DEPTH cycles. The first RUN grant is possible on cycle DEPTH after reset deassertion.
- Read latency: 1 cycle from handshake to `resp_valid`. Throughput: one access per cycle across both requesters.
- Under continuous contention, grants alternate every cycle (max wait 1 cycle).
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight response is dropped.

## Structure
- Shared package: state encoding (ST_INIT, ST_RUN).
- Sub-module `common_rrarb2`: 2-way round-robin arbiter holding `rr_ptr`, with valid inputs, grant outputs and an accept input.
- The top instantiates the arbiter and contains the INIT counter, FSM and response registers. The RAM stays external.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2, INIT_VALUE=8'hA5.
- Reset, INIT_ON_RESET=1:
  - `init_busy` is high for 4 cycles, with `ram_addr` 0,1,2,3 and `ram_we`=1.
  - Then a read of addr 2 from req0 → `resp0_valid` next cycle with 8'hA5.
- req0 writes 8'h3C to addr 1, then req1 reads addr 1 the next cycle → `resp1_dout`=8'h3C one cycle later; `resp0_valid` never pulses.
- Both requesters valid continuously for 6 cycles → grants 0,1,0,1,0,1. Each ready is high only on its granted cycle.
- Only req1 valid for 3 cycles → req1 accepted every cycle. `rr_ptr` ends at 0.
- `init_req` pulsed in RUN with req0 valid → req0 accepted that cycle. INIT runs 4 cycles with ready low. A prior write of 8'h3C at addr 1 now reads 8'hA5.
- Reset asserted during INIT at cnt=2 → `init_busy` restarts and INIT runs a full 4 cycles again. Reset asserted the cycle after a read handshake → `resp_valid` stays 0.
